puf_window_timer: RTL and testbench

- Generates the measurement window for ring-oscillator PUF counters.
- Drives the clock-enable request (CE_in side) and the time_stop signal consumed by the CE gating logic in front of each RO counter.
- A start pulse opens a window of exactly window_len clock cycles, during which ce_req=1 and time_stop=0.
- time_stop then asserts and is held, freezing the RO counts, until software/readout logic acknowledges with clear.

---
 rtl/puf_window_timer.sv | 94 +++++++++
 tb/tb_puf_window_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_window_timer.sv
// Measurement-window timer for ring-oscillator PUF counters: drives the CE gating
// (ce_req / time_stop) for exactly window_len cycles, then freezes until clear.
module puf_window_timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] window_len,
    output logic                 ce_req,
    output logic                 time_stop,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] elapsed,
    output logic [1:0]           dbg_state
);

    // Level-only control: start is honoured in IDLE, clear in STOP, abort in RUN/STOP.
    // abort has priority over clear and over the RUN->STOP transition.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] elapsed_d;
    logic                 done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            elapsed   <= '0;
            done      <= 1'b0;
            ce_req    <= 1'b0;
            time_stop <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            elapsed   <= elapsed_d;
            done      <= done_d;
            ce_req    <= (state_d != IDLE);
            time_stop <= (state_d == STOP);
            busy      <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        elapsed_d = elapsed;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = window_len;
                    elapsed_d = '0;
                    if (window_len == '0) begin
                        state_d = STOP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // The abort edge still counts as a completed RUN cycle.
                elapsed_d = elapsed + CNT_ONE;
                if (abort) begin
                    state_d = IDLE;
                end else if (elapsed == len_q - CNT_ONE) begin
                    state_d = STOP;
                    done_d  = 1'b1;
                end
            end
            STOP: begin
                if (abort || clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_puf_window_timer.sv
// Bench for puf_window_timer: a 32-bit and a 4-bit instance checked every cycle
// against a window model expressed as cycle arithmetic from the accepted start.
module tb_puf_window_timer;

    typedef struct {
        bit     active;
        longint t0;
        longint len;
        longint frozen;
    } model_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, clear = 1'b0;
    logic [31:0] window_len = '0;
    logic        ce_req, time_stop, busy, done;
    logic [31:0] elapsed;
    logic [1:0]  dbg_state;

    logic        start4 = 1'b0, abort4 = 1'b0, clear4 = 1'b0;
    logic [3:0]  window_len4 = '0;
    logic        ce_req4, time_stop4, busy4, done4;
    logic [3:0]  elapsed4;
    logic [1:0]  dbg_state4;

    int     n_vec = 0;
    int     n_mis = 0;
    longint now = 0;
    model_t m32, m4;

    always #5 clk = ~clk;

    puf_window_timer #(.CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear(clear),
        .window_len(window_len), .ce_req(ce_req), .time_stop(time_stop),
        .busy(busy), .done(done), .elapsed(elapsed), .dbg_state(dbg_state)
    );

    puf_window_timer #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .clear(clear4),
        .window_len(window_len4), .ce_req(ce_req4), .time_stop(time_stop4),
        .busy(busy4), .done(done4), .elapsed(elapsed4), .dbg_state(dbg_state4)
    );

    function automatic model_t model_reset();
        model_t r;
        r.active = 1'b0;
        r.t0     = 0;
        r.len    = 0;
        r.frozen = 0;
        return r;
    endfunction

    // Edge at index e, with the inputs present just before that edge.
    function automatic model_t model_edge(model_t m, bit st, bit ab, bit cl, longint wl, longint e);
        model_t r = m;
        longint ran;
        if (!m.active) begin
            if (st) begin
                r.active = 1'b1;
                r.t0     = e;
                r.len    = wl;
            end
        end else begin
            ran = e - m.t0;
            if (ab) begin
                r.active = 1'b0;
                r.frozen = (ran < m.len) ? ran : m.len;
            end else if (cl && (ran - 1) >= m.len) begin
                r.active = 1'b0;
                r.frozen = m.len;
            end
        end
        return r;
    endfunction

    task automatic check_one(input string tag, input model_t m, input longint e,
                             input logic a_ce, input logic a_ts, input logic a_busy,
                             input logic a_done, input logic [31:0] a_el, input int w);
        logic        x_ce, x_ts, x_busy, x_done;
        logic [31:0] x_el;
        longint      d;
        if (m.active) begin
            d      = e - m.t0;
            x_ce   = 1'b1;
            x_busy = 1'b1;
            x_ts   = (d >= m.len);
            x_done = (d == m.len);
            x_el   = 32'((d < m.len) ? d : m.len);
        end else begin
            x_ce   = 1'b0;
            x_busy = 1'b0;
            x_ts   = 1'b0;
            x_done = 1'b0;
            x_el   = 32'(m.frozen);
        end
        if (w < 32) x_el = x_el & ((32'd1 << w) - 32'd1);
        n_vec++;
        assert (a_ce === x_ce) else begin
            n_mis++;
            $error("FAIL %s ce_req cyc=%0d got %0b want %0b", tag, e, a_ce, x_ce);
        end
        n_vec++;
        assert (a_ts === x_ts) else begin
            n_mis++;
            $error("FAIL %s time_stop cyc=%0d got %0b want %0b", tag, e, a_ts, x_ts);
        end
        n_vec++;
        assert (a_busy === x_busy) else begin
            n_mis++;
            $error("FAIL %s busy cyc=%0d got %0b want %0b", tag, e, a_busy, x_busy);
        end
        n_vec++;
        assert (a_done === x_done) else begin
            n_mis++;
            $error("FAIL %s done cyc=%0d got %0b want %0b", tag, e, a_done, x_done);
        end
        n_vec++;
        assert (a_el === x_el) else begin
            n_mis++;
            $error("FAIL %s elapsed cyc=%0d got %0d want %0d", tag, e, a_el, x_el);
        end
    endtask

    task automatic check_all(input string tag);
        check_one({tag, "_w32"}, m32, now, ce_req, time_stop, busy, done, elapsed, 32);
        check_one({tag, "_w4"}, m4, now, ce_req4, time_stop4, busy4, done4,
                  {28'd0, elapsed4}, 4);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        m32 = model_edge(m32, start, abort, clear, longint'(window_len), now);
        m4  = model_edge(m4, start4, abort4, clear4, longint'(window_len4), now);
        #1;
        check_all(tag);
        now++;
    endtask

    task automatic cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        m32 = model_reset();
        m4  = model_reset();

        // Reset asserted from time 0, released between edges.
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles("idle", 2);

        // Window of 5: RUN for 5 cycles, STOP held, clear returns to IDLE.
        window_len = 32'd5;
        start = 1'b1;
        cycle("w5_start");
        start = 1'b0;
        cycles("w5_run", 8);
        n_vec++;
        assert (elapsed === 32'd5) else begin
            n_mis++;
            $error("FAIL w5_hold elapsed got %0d want 5", elapsed);
        end
        clear = 1'b1;
        cycle("w5_clear");
        clear = 1'b0;
        cycles("w5_idle", 2);

        // Zero-length window goes straight to STOP with done.
        window_len = 32'd0;
        start = 1'b1;
        cycle("w0_start");
        start = 1'b0;
        cycles("w0_stop", 3);
        clear = 1'b1;
        cycle("w0_clear");
        clear = 1'b0;
        cycle("w0_idle");

        // Abort at elapsed=4 of a 10-cycle window.
        window_len = 32'd10;
        start = 1'b1;
        cycle("w10_start");
        start = 1'b0;
        cycles("w10_run", 4);
        abort = 1'b1;
        cycle("w10_abort");
        abort = 1'b0;
        n_vec++;
        assert (elapsed === 32'd5 && done === 1'b0 && busy === 1'b0) else begin
            n_mis++;
            $error("FAIL w10_abort elapsed=%0d done=%0b busy=%0b want 5/0/0", elapsed, done, busy);
        end
        cycles("w10_idle", 2);

        // Start held high, window_len changed mid-RUN, second window after clear.
        window_len = 32'd3;
        start = 1'b1;
        cycle("w3_start");
        window_len = 32'd7;
        cycles("w3_held", 6);
        clear = 1'b1;
        cycle("w3_clear");
        clear = 1'b0;
        cycles("w7_second", 10);
        abort = 1'b1;
        cycle("w7_abort");
        abort = 1'b0;
        start = 1'b0;
        cycle("w7_idle");

        // Abort on the edge that would have entered STOP.
        window_len = 32'd4;
        start = 1'b1;
        cycle("w4_start");
        start = 1'b0;
        cycles("w4_run", 3);
        abort = 1'b1;
        cycle("w4_abort_last");
        abort = 1'b0;
        cycles("w4_idle", 2);

        // Narrow instance: full-scale length, then clear and start together.
        window_len4 = 4'd15;
        start4 = 1'b1;
        cycle("n15_start");
        start4 = 1'b0;
        cycles("n15_run", 18);
        clear4 = 1'b1;
        start4 = 1'b1;
        cycle("n15_clear_start");
        clear4 = 1'b0;
        start4 = 1'b0;
        cycles("n15_idle", 2);

        // Asynchronous reset in the middle of a window.
        window_len = 32'd8;
        start = 1'b1;
        window_len4 = 4'd9;
        start4 = 1'b1;
        cycle("rst_start");
        start = 1'b0;
        start4 = 1'b0;
        cycles("rst_run", 3);
        #2;
        rst_n = 1'b0;
        #1;
        m32 = model_reset();
        m4  = model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycles("rst_idle", 2);

        // Randomized control traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 19) == 0);
            clear       = ($urandom_range(0, 4) == 0);
            window_len  = 32'($urandom_range(0, 12));
            start4      = ($urandom_range(0, 3) == 0);
            abort4      = ($urandom_range(0, 19) == 0);
            clear4      = ($urandom_range(0, 4) == 0);
            window_len4 = 4'($urandom_range(0, 15));
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
